// File: rtl/multi_ch_fifo_pkg.sv
// rtl/multi_ch_fifo_pkg.sv - shared defaults and bus slicing helper for multi_ch_fifo
package multi_ch_fifo_pkg;

   localparam int DEF_DWIDTH    = 32;
   localparam int DEF_AWIDTH    = 4;
   localparam int DEF_CH        = 4;
   localparam int DEF_PF_THRESH = 12;

   // Low bit of channel c inside a bus packed as CH fields of width w
   function automatic int ch_lsb(input int c, input int w);
      return c * w;
   endfunction

endpackage

// File: rtl/fifo_channel.sv
// rtl/fifo_channel.sv - one independent FIFO channel; MULTI_CH_FIFO_STATS_EN adds peak_count
module fifo_channel
   import multi_ch_fifo_pkg::*;
#(
   parameter int DWIDTH    = DEF_DWIDTH,
   parameter int AWIDTH    = DEF_AWIDTH,
   parameter int FWFT      = 0,
   parameter int PF_THRESH = DEF_PF_THRESH
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [DWIDTH-1:0] din,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] dout,
   output logic              valid,
   output logic              full,
   output logic              prog_full,
   output logic              empty,
   output logic [AWIDTH:0]   data_count,
`ifdef MULTI_CH_FIFO_STATS_EN
   output logic [AWIDTH:0]   peak_count,
`endif
   output logic              overflow,
   output logic              underflow
);

   localparam int DEPTH = 1 << AWIDTH;
   localparam int CW    = AWIDTH + 1;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH:0]   wr_ptr, rd_ptr, count;
   logic              full_i, empty_i, wr_acc, rd_acc;
   logic              ovf_q, udf_q;

   // The extra wrap bit lets all DEPTH entries be used and count reach DEPTH
   assign count   = wr_ptr - rd_ptr;
   assign full_i  = (count == CW'(DEPTH));
   assign empty_i = (count == '0);
   assign wr_acc  = wr_en & ~full_i & ~srst;
   assign rd_acc  = rd_en & ~empty_i & ~srst;

   assign data_count = count;
   assign full       = full_i | srst;
   assign empty      = empty_i | srst;
   assign prog_full  = (count >= CW'(PF_THRESH)) | srst;
   assign overflow   = ovf_q & ~srst;
   assign underflow  = udf_q & ~srst;

   // Pointer advance and one-cycle error pulses for rejected requests
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + CW'(wr_acc);
         rd_ptr <= rd_ptr + CW'(rd_acc);
         ovf_q  <= wr_en & full_i;
         udf_q  <= rd_en & empty_i;
      end
   end

   // Storage is deliberately not cleared by reset
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr[AWIDTH-1:0]] <= din;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign dout  = mem[rd_ptr[AWIDTH-1:0]];
         assign valid = ~empty_i & ~srst;
      end else begin : g_std
         logic [DWIDTH-1:0] dout_q;
         logic              valid_q;
         // Registered read port: data only on the cycle after an accepted pop
         always_ff @(posedge clk) begin
            if (srst) begin
               dout_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               valid_q <= rd_acc;
               dout_q  <= rd_acc ? mem[rd_ptr[AWIDTH-1:0]] : '0;
            end
         end
         assign dout  = dout_q;
         assign valid = valid_q & ~srst;
      end
   endgenerate

`ifdef MULTI_CH_FIFO_STATS_EN
   logic [AWIDTH:0] peak_q;
   // High-water mark of occupancy since the last reset
   always_ff @(posedge clk) begin
      if (srst)                peak_q <= '0;
      else if (count > peak_q) peak_q <= count;
   end
   assign peak_count = peak_q;
`endif

endmodule

// File: rtl/multi_ch_fifo.sv
// rtl/multi_ch_fifo.sv - CH independent FIFOs on packed buses; MULTI_CH_FIFO_STATS_EN adds peak_count
module multi_ch_fifo
   import multi_ch_fifo_pkg::*;
#(
   parameter int DWIDTH    = DEF_DWIDTH,
   parameter int AWIDTH    = DEF_AWIDTH,
   parameter int CH        = DEF_CH,
   parameter int FWFT      = 0,
   parameter int PF_THRESH = DEF_PF_THRESH
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic [CH*DWIDTH-1:0]     din,
   input  logic [CH-1:0]            wr_en,
   input  logic [CH-1:0]            rd_en,
   output logic [CH*DWIDTH-1:0]     dout,
   output logic [CH-1:0]            valid,
   output logic [CH-1:0]            full,
   output logic [CH-1:0]            prog_full,
   output logic [CH-1:0]            empty,
   output logic [CH*(AWIDTH+1)-1:0] data_count,
`ifdef MULTI_CH_FIFO_STATS_EN
   output logic [CH*(AWIDTH+1)-1:0] peak_count,
`endif
   output logic [CH-1:0]            overflow,
   output logic [CH-1:0]            underflow
);

   localparam int CW = AWIDTH + 1;

   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         fifo_channel #(
            .DWIDTH   (DWIDTH),
            .AWIDTH   (AWIDTH),
            .FWFT     (FWFT),
            .PF_THRESH(PF_THRESH)
         ) u_ch (
            .clk       (clk),
            .srst      (srst),
            .din       (din[ch_lsb(c, DWIDTH) +: DWIDTH]),
            .wr_en     (wr_en[c]),
            .rd_en     (rd_en[c]),
            .dout      (dout[ch_lsb(c, DWIDTH) +: DWIDTH]),
            .valid     (valid[c]),
            .full      (full[c]),
            .prog_full (prog_full[c]),
            .empty     (empty[c]),
            .data_count(data_count[ch_lsb(c, CW) +: CW]),
`ifdef MULTI_CH_FIFO_STATS_EN
            .peak_count(peak_count[ch_lsb(c, CW) +: CW]),
`endif
            .overflow  (overflow[c]),
            .underflow (underflow[c])
         );
      end
   endgenerate

endmodule
